// File: rtl/mem8x8_arbiter_if.sv
// mem8x8_arbiter_if
//   Bundles the requester-side handshake and the memory-side control/data
//   bus of the 8x8 memory arbiter.
//   slave  : the arbiter's view. It receives requests and memory status and
//            drives grants, completion, read data and memory control.
//   master : the surrounding system's view (requesters plus memory group).
//   Requester side: req, we, addr0/1, wdata0/1 in; gnt, done, err, rdata out.
//   Memory side   : mem_sel, mem_rw, mem_addr, mem_wdata, mem_drive out;
//                   mem_valid, mem_rdata in.
interface mem8x8_arbiter_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic          mem_sel;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_drive;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_valid, mem_rdata,
    output gnt, done, err, rdata, mem_sel, mem_rw, mem_addr, mem_wdata, mem_drive
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_valid, mem_rdata,
    input  gnt, done, err, rdata, mem_sel, mem_rw, mem_addr, mem_wdata, mem_drive
  );
endinterface

// File: rtl/mem8x8_arbiter.sv
// mem8x8_arbiter
//   Two-port round-robin arbiter and access sequencer for the shared 8x8
//   memory. Serialises requests onto the single sel/op control interface,
//   enables the write-data tri-state driver only during write accesses, and
//   captures read data when the memory FSM reports valid. Accesses that see
//   no valid within TIMEOUT cycles are aborted and flagged with err.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : mem8x8_arbiter_if.slave (requester handshake + memory bus)
module mem8x8_arbiter #(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem8x8_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;   // requester index of current access
  logic          last_reg,  last_next;    // owner of the previous access
  logic          we_reg,    we_next;
  logic          err_reg,   err_next;     // set when the access timed out
  logic [7:0]    cnt_reg,   cnt_next;     // ACCESS cycles already spent
  logic [AW-1:0] addr_reg,  addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;   // requester 0 wins the first contention
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      we_reg    <= we_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    we_next    = we_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    winner     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          // Single request wins outright; on contention the non-last one wins.
          winner     = (bus.req[0] && bus.req[1]) ? ~last_reg : bus.req[1];
          owner_next = winner;
          we_next    = bus.we[winner];
          addr_next  = winner ? bus.addr1  : bus.addr0;
          wdata_next = winner ? bus.wdata1 : bus.wdata0;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_valid) begin
          if (!we_reg) begin
            rdata_next = bus.mem_rdata;
          end
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: begin
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory controls are decoded from the state register so that an
  // asynchronous reset removes sel and the bus driver immediately. The
  // driver is gated by the latched op, so reads never drive the bus.
  assign bus.mem_sel   = (state_reg == ACCESS);
  assign bus.mem_rw    = (state_reg == ACCESS) && we_reg;
  assign bus.mem_drive = (state_reg == ACCESS) && we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.err       = (state_reg == DONE) && err_reg;
  assign bus.rdata     = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign bus.gnt[gi]  = (state_reg != IDLE) && (owner_reg == 1'(gi));
      assign bus.done[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// tb_mem8x8_arbiter
//   Self-checking bench for mem8x8_arbiter. A memory responder answers each
//   access after a programmable number of ACCESS cycles; expected owners,
//   latencies, error flags and read data come from a transaction-level model.
module tb_mem8x8_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk;
  logic rst_n;

  mem8x8_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem8x8_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // memory device contents and reference model state
  logic [DW-1:0] dev_mem [8];
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] ref_rdata;
  logic          ref_last;
  int            vdelay;      // ACCESS cycles before the memory answers

  // per-requester stimulus fields
  logic          r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];

  typedef struct {
    logic [1:0]    gnt_acc;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
    int            acc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rw;
    logic          drive_seen;
    int            viol;
    bit            to;
  } obs_t;

  // Memory responder: answers on ACCESS cycle index vdelay (0-based).
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_sel) begin
        if (acc == vdelay) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = dev_mem[bus.mem_addr];
          if (bus.mem_rw) dev_mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_valid = 1'b0;
          bus.mem_rdata = DW'($urandom);
        end
        acc++;
      end else begin
        acc = 0;
        bus.mem_valid = 1'b0;
      end
    end
  end

  task automatic drive_fields(input int i);
    if (i == 0) begin
      bus.addr0 = r_addr[0]; bus.wdata0 = r_wdata[0];
    end else begin
      bus.addr1 = r_addr[1]; bus.wdata1 = r_wdata[1];
    end
    bus.we[i] = r_we[i];
  endtask

  task automatic rand_fields(input int i);
    r_we[i]    = 1'($urandom);
    r_addr[i]  = AW'($urandom);
    r_wdata[i] = DW'($urandom);
    drive_fields(i);
  endtask

  // Watches one access until done, recording what was seen (no checking).
  task automatic observe(output obs_t o);
    bit first;
    first = 1'b1;
    o = '{default: '0};
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.mem_drive && !bus.mem_rw) o.viol++;
      if (bus.mem_drive && !bus.mem_sel) o.viol++;
      if (!$onehot0(bus.gnt)) o.viol++;
      if (bus.mem_sel) begin
        if (bus.gnt == 2'b00) o.viol++;
        o.acc++;
        if (bus.mem_drive) o.drive_seen = 1'b1;
        if (first) begin
          o.gnt_acc = bus.gnt; o.addr = bus.mem_addr;
          o.wdata = bus.mem_wdata; o.rw = bus.mem_rw;
          first = 1'b0;
        end
      end
      if (bus.done != 2'b00) begin
        o.done = bus.done; o.gnt = bus.gnt; o.err = bus.err; o.rdata = bus.rdata;
        return;
      end
    end
    o.to = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.gnt, bus.done, bus.err, bus.mem_sel, bus.mem_rw, bus.mem_drive} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.gnt, bus.done, bus.err, bus.mem_sel, bus.mem_rw, bus.mem_drive});
    end
    n_tests++;
    if ({bus.rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp=0", bus.rdata, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    ref_last = 1'b1; ref_rdata = '0;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_write_min;
    r_we[0] = 1'b1; r_addr[0] = 3'd3; r_wdata[0] = 8'hA5; drive_fields(0);
    vdelay = 0;
    bus.req = 2'b01;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_sel, bus.mem_rw, bus.mem_drive, bus.gnt, bus.done} !== 7'b111_01_00) begin
      n_fail++;
      $display("FAIL wr_access sel/rw/drv/gnt/done got=%b exp=1110100", {bus.mem_sel, bus.mem_rw, bus.mem_drive, bus.gnt, bus.done});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== {3'd3, 8'hA5}) begin
      n_fail++;
      $display("FAIL wr_latch addr=%h wdata=%h exp=3/a5", bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.done, bus.gnt, bus.err, bus.mem_sel, bus.mem_drive} !== 7'b01_01_000) begin
      n_fail++;
      $display("FAIL wr_done done/gnt/err/sel/drv got=%b exp=0101000", {bus.done, bus.gnt, bus.err, bus.mem_sel, bus.mem_drive});
    end
    bus.req = 2'b00;
    @(negedge clk);
    n_tests++;
    if ({bus.gnt, bus.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_idle gnt=%b done=%b exp=00/00", bus.gnt, bus.done);
    end
    ref_last = 1'b0; ref_mem[3] = 8'hA5;
    $display("[TB] write addr=3 data=a5 done");
  endtask

  task automatic test_read_delay;
    obs_t o;
    r_we[0] = 1'b0; r_addr[0] = 3'd3; drive_fields(0);
    vdelay = 2;
    bus.req = 2'b01;
    observe(o);
    bus.req = 2'b00;
    n_tests++;
    if (o.to || o.acc != 3 || o.drive_seen || o.viol != 0 || o.done !== 2'b01 || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_delay to=%0d acc=%0d drv=%b viol=%0d done=%b err=%b exp acc=3 drv=0 done=01 err=0",
               o.to, o.acc, o.drive_seen, o.viol, o.done, o.err);
    end
    n_tests++;
    if (o.rdata !== ref_mem[3]) begin
      n_fail++;
      $display("FAIL rd_data got=%h exp=%h", o.rdata, ref_mem[3]);
    end
    ref_rdata = ref_mem[3]; ref_last = 1'b0;
    @(negedge clk);
    $display("[TB] read addr=3 delay=2 rdata=%h", o.rdata);
  endtask

  task automatic test_alternate;
    obs_t o;
    logic exp_o;
    logic [DW-1:0] exp_rd;
    rand_fields(0); rand_fields(1);
    bus.req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      vdelay = $urandom_range(0, 4);
      exp_o = ~ref_last;
      observe(o);
      exp_rd = (!r_we[exp_o]) ? ref_mem[r_addr[exp_o]] : ref_rdata;
      n_tests++;
      if (o.to || o.gnt !== (2'b01 << exp_o) || o.gnt_acc !== (2'b01 << exp_o) ||
          o.done !== (2'b01 << exp_o) || o.err !== 1'b0 || o.acc != vdelay + 1 || o.viol != 0) begin
        n_fail++;
        $display("FAIL alt_%0d to=%0d gnt=%b done=%b err=%b acc=%0d viol=%0d exp owner=%0d acc=%0d",
                 k, o.to, o.gnt, o.done, o.err, o.acc, o.viol, exp_o, vdelay + 1);
      end
      n_tests++;
      if (o.rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL alt_rdata_%0d got=%h exp=%h", k, o.rdata, exp_rd);
      end
      if (r_we[exp_o]) ref_mem[r_addr[exp_o]] = r_wdata[exp_o];
      else ref_rdata = exp_rd;
      ref_last = exp_o;
      $display("[TB] alt %0d owner=%0d we=%b addr=%0d rdata=%h", k, exp_o, r_we[exp_o], r_addr[exp_o], o.rdata);
      bus.req[exp_o] = 1'b0;
      @(negedge clk);
      rand_fields(int'(exp_o));
      bus.req[exp_o] = 1'b1;
    end
    // let the final pending request finish, then go quiet
    vdelay = 0;
    observe(o);
    ref_last = ~ref_last;
    if (o.done[0] && !r_we[0]) ref_rdata = ref_mem[r_addr[0]];
    if (o.done[1] && !r_we[1]) ref_rdata = ref_mem[r_addr[1]];
    if (o.done[0] && r_we[0]) ref_mem[r_addr[0]] = r_wdata[0];
    if (o.done[1] && r_we[1]) ref_mem[r_addr[1]] = r_wdata[1];
    bus.req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    obs_t o;
    r_we[0] = 1'b0; r_addr[0] = AW'($urandom); drive_fields(0);
    vdelay = 255;
    bus.req = 2'b01;
    observe(o);
    bus.req = 2'b00;
    n_tests++;
    if (o.to || o.acc != TO || o.done !== 2'b01 || o.err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout to=%0d acc=%0d done=%b err=%b exp acc=%0d done=01 err=1", o.to, o.acc, o.done, o.err, TO);
    end
    n_tests++;
    if (o.rdata !== ref_rdata) begin
      n_fail++;
      $display("FAIL timeout_rdata got=%h exp=%h", o.rdata, ref_rdata);
    end
    ref_last = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.err, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_err_pulse err=%b done=%b exp=0/00", bus.err, bus.done);
    end
    $display("[TB] timeout read acc=%0d err=%b", o.acc, o.err);
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int dones;
    r_we[1] = 1'b1; r_addr[1] = 3'd5; r_wdata[1] = 8'h3C; drive_fields(1);
    vdelay = 255;
    bus.req = 2'b10;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.mem_sel !== 1'b1 || bus.mem_drive !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre sel=%b drv=%b exp=1/1", bus.mem_sel, bus.mem_drive);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.gnt, bus.done, bus.err, bus.mem_sel, bus.mem_rw, bus.mem_drive, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async gnt=%b done=%b err=%b sel=%b rw=%b drv=%b addr=%h wd=%h rd=%h exp=all 0",
               bus.gnt, bus.done, bus.err, bus.mem_sel, bus.mem_rw, bus.mem_drive, bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done != 2'b00) dones++;
    end
    bus.req = 2'b00;
    rst_n = 1'b1;
    ref_last = 1'b1; ref_rdata = '0;
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rstmid_done got=%0d pulses exp=0", dones);
    end
    @(negedge clk);
    rand_fields(0); rand_fields(1);
    vdelay = 0;
    bus.req = 2'b11;
    observe(o);
    bus.req[0] = 1'b0;
    n_tests++;
    if (o.to || o.done !== 2'b01 || o.gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_first_grant to=%0d done=%b gnt=%b exp=01/01", o.to, o.done, o.gnt);
    end
    if (r_we[0]) ref_mem[r_addr[0]] = r_wdata[0];
    else ref_rdata = ref_mem[r_addr[0]];
    ref_last = 1'b0;
    // requester 1 still pending: let it complete
    observe(o);
    bus.req = 2'b00;
    if (r_we[1]) ref_mem[r_addr[1]] = r_wdata[1];
    else ref_rdata = ref_mem[r_addr[1]];
    ref_last = 1'b1;
    @(negedge clk);
    $display("[TB] reset mid-access checked");
  endtask

  task automatic test_req_drop;
    obs_t o;
    logic [AW-1:0] a;
    a = AW'($urandom);
    r_we[0] = 1'b0; r_addr[0] = a; drive_fields(0);
    vdelay = 1;
    bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    bus.addr0 = ~a;
    observe(o);
    n_tests++;
    if (o.to || o.done !== 2'b01 || o.err !== 1'b0 || o.acc != 1) begin
      n_fail++;
      $display("FAIL req_drop to=%0d done=%b err=%b acc=%0d exp done=01 err=0 acc=1", o.to, o.done, o.err, o.acc);
    end
    n_tests++;
    if (o.addr !== a || o.rdata !== ref_mem[a]) begin
      n_fail++;
      $display("FAIL req_drop_latch addr=%h rdata=%h exp addr=%h rdata=%h", o.addr, o.rdata, a, ref_mem[a]);
    end
    ref_rdata = ref_mem[a]; ref_last = 1'b0;
    @(negedge clk);
    $display("[TB] req dropped in ACCESS, done=%b", o.done);
  endtask

  task automatic test_random;
    obs_t o;
    logic [1:0] pat;
    logic exp_o, exp_err;
    logic [DW-1:0] exp_rd;
    int exp_acc;
    for (int k = 0; k < 24; k++) begin
      rand_fields(0); rand_fields(1);
      pat = 2'($urandom_range(1, 3));
      vdelay = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 5);
      exp_o   = (pat == 2'b11) ? ~ref_last : pat[1];
      exp_err = (vdelay >= TO);
      exp_acc = exp_err ? TO : vdelay + 1;
      exp_rd  = (!exp_err && !r_we[exp_o]) ? ref_mem[r_addr[exp_o]] : ref_rdata;
      bus.req = pat;
      observe(o);
      bus.req = 2'b00;
      n_tests++;
      if (o.to || o.done !== (2'b01 << exp_o) || o.gnt !== (2'b01 << exp_o) || o.err !== exp_err ||
          o.acc != exp_acc || o.viol != 0 || o.rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rand_%0d to=%0d done=%b err=%b acc=%0d viol=%0d rdata=%h exp owner=%0d err=%b acc=%0d rdata=%h",
                 k, o.to, o.done, o.err, o.acc, o.viol, o.rdata, exp_o, exp_err, exp_acc, exp_rd);
      end
      n_tests++;
      if (o.addr !== r_addr[exp_o] || o.rw !== r_we[exp_o] || (r_we[exp_o] && o.wdata !== r_wdata[exp_o])) begin
        n_fail++;
        $display("FAIL rand_latch_%0d addr=%h rw=%b wd=%h exp addr=%h rw=%b wd=%h",
                 k, o.addr, o.rw, o.wdata, r_addr[exp_o], r_we[exp_o], r_wdata[exp_o]);
      end
      if (!exp_err) begin
        if (r_we[exp_o]) ref_mem[r_addr[exp_o]] = r_wdata[exp_o];
        else ref_rdata = exp_rd;
      end
      ref_last = exp_o;
      $display("[TB] rand %0d req=%b owner=%0d we=%b addr=%0d delay=%0d err=%b rdata=%h",
               k, pat, exp_o, r_we[exp_o], r_addr[exp_o], vdelay, o.err, o.rdata);
      @(negedge clk);
      n_tests++;
      if ({bus.gnt, bus.done, bus.mem_sel} !== 5'b0) begin
        n_fail++;
        $display("FAIL rand_idle_%0d gnt=%b done=%b sel=%b exp=0", k, bus.gnt, bus.done, bus.mem_sel);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mem_valid = 1'b0; bus.mem_rdata = '0;
    vdelay = 0;
    for (int i = 0; i < 8; i++) begin
      dev_mem[i] = DW'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    ref_last = 1'b1; ref_rdata = '0;

    test_reset;
    test_write_min;
    test_read_delay;
    test_alternate;
    test_timeout;
    test_reset_mid;
    test_req_drop;
    test_random;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem8x8_arbiter.md
# mem8x8_arbiter

Two-port round-robin arbiter and access sequencer for the shared 8x8 memory. It accepts read/write requests from two requesters, serialises them onto the memory's single `sel`/`op` control interface, drives the write data onto the tri-state data bus only when the access is a write, and captures read data when the memory control FSM reports `valid`. It sits between the two bus masters and the memory/FSM/tri-state buffer group. It never lets both requesters drive the bus, and it never lets the arbiter and the memory drive the bus at the same time.

## Interface
Parameters:
- AW, 3, address width (8 words)
- DW, 8, data width
- TIMEOUT, 15, maximum ACCESS cycles spent waiting for `mem_valid` before the access is aborted (legal range 1..255)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  access request per requester; held high until that requester's `done` pulse
- we  in  2  per requester: 1 = write, 0 = read; qualified by `req`
- addr0, addr1  in  AW  address for requester 0 / requester 1
- wdata0, wdata1  in  DW  write data for requester 0 / requester 1
- gnt  out  2  one-hot or zero; marks the current owner during ACCESS and DONE
- done  out  2  one-cycle completion pulse to the owner
- err  out  1  one-cycle pulse, coincident with `done`, when the access timed out
- rdata  out  DW  last successful read data; held until the next successful read
- mem_sel  out  1  memory select, driven to the memory FSM `sel` input
- mem_rw  out  1  driven to the memory FSM `op` input: 1 = write, 0 = read
- mem_addr  out  AW  latched access address
- mem_wdata  out  DW  latched write data, placed on the tri-state bus
- mem_drive  out  1  tri-state enable for `mem_wdata`
- mem_valid  in  1  `valid` output of the memory FSM
- mem_rdata  in  DW  memory read data

## Operation
- The arbiter has three states: IDLE, ACCESS and DONE.
- **Reset value of every register and output is 0**: state = IDLE, gnt, done, err, rdata, mem_sel, mem_rw, mem_addr, mem_wdata, mem_drive, timeout counter. The round-robin pointer `last` resets to 1, so requester 0 wins the first contention.
- **IDLE**:
  - No requests pending: stay in IDLE.
  - Exactly one request pending: that requester wins.
  - Both requests pending: the requester that is not `last` wins.
  - On the same clock edge that the winner is chosen: latch the winner's addr, we and wdata into the `mem_*` registers, set `gnt[winner]`, clear the timeout counter, and go to ACCESS.
- **ACCESS**:
  - mem_sel = 1 and mem_rw = latched we.
  - mem_drive = 1 only if the access is a write, so the bus is never driven during a read.
  - `mem_valid` = 1 at a clock edge: for a read, capture `mem_rdata` into `rdata`; then go to DONE.
  - `mem_valid` = 0 and counter = TIMEOUT-1: go to DONE with the error flag set.
  - Otherwise: increment the counter and stay in ACCESS.
- **DONE** (exactly one cycle):
  - done[owner] = 1 and gnt[owner] stays 1.
  - err = 1 only if the access timed out.
  - mem_sel = 0 and mem_drive = 0. This gives one idle turnaround cycle on the bus.
  - On exit: set `last` = owner, clear gnt, and go to IDLE.
- **Latched request**: once in ACCESS, the access completes using the latched values even if `req`, `addr` or `wdata` change or `req` drops. `done` still pulses.
- **Error abort**: an aborted read leaves `rdata` unchanged. An aborted write has undefined memory contents.
- **Requester obligation**: a requester must deassert `req` in the cycle after its `done` pulse. A `req` still high in IDLE is treated as a new request, and it loses to a pending request from the other requester.
- **Reset mid-operation**: `rst_n` low forces all outputs to 0 immediately, without waiting for a clock edge, including mem_sel and mem_drive. Any in-flight access is dropped with no `done` pulse.

## Timing
- **Minimum sequence**: `req` sampled high at edge k (state IDLE) → ACCESS during k..k+1 → `mem_valid` high at edge k+1 → `done` high during k+1..k+2 → IDLE at k+2.
- **Minimum throughput**: one access per 3 cycles. Back-to-back requests alternate owners.
- **Latency**: each cycle that `mem_valid` stays low extends ACCESS by one cycle, up to TIMEOUT cycles in ACCESS.
- **Read data timing**: `rdata` is updated at the edge that leaves ACCESS and is valid when `done` is high.
- **Bus exclusivity**: mem_drive is never 1 while mem_rw = 0, and never 1 outside ACCESS.

## Test plan
- Reset, then req = 01 with we0 = 1, addr0 = 3, wdata0 = 0xA5, mem_valid high on the first ACCESS cycle → mem_sel/mem_rw/mem_drive = 1 for 1 cycle, done = 01 two cycles after the request was sampled, err = 0.
- Requester 0 reads addr 3 with mem_rdata = 0xA5 and mem_valid delayed 2 cycles → ACCESS lasts 3 cycles, mem_drive stays 0, rdata = 0xA5 when done = 01.
- req = 11 held continuously, each requester dropping `req` one cycle after its own `done` and then re-raising it → grants alternate 0, 1, 0, 1, and exactly one gnt bit is high at any time.
- mem_valid held at 0 with TIMEOUT = 15 → 15 ACCESS cycles, then done = 01 together with err = 1, and rdata keeps its previous value.
- rst_n pulsed low in the middle of an ACCESS → all outputs go to 0 asynchronously, no done pulse, and the first request after reset is granted to requester 0.
- req0 dropped in the first ACCESS cycle → access completes normally and done = 01 still pulses.
